// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - opcodes, state encodings and control-word type for the multi-cycle controller
package multicycle_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // fetch_gate marks strobes that only fire once memory reports ready
    typedef struct packed {
        logic       pc_write;
        logic       fetch_gate;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_dec.sv
// rtl/multicycle_ctrl_dec.sv - pure state to control-word decoder
module multicycle_ctrl_dec
    import multicycle_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read   = 1'b1;
                ctrl.fetch_gate = 1'b1;
                ctrl.alu_src_b  = SRCB_FOUR;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM of the multi-cycle MIPS datapath
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int OP_W = 6,
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] op,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            mem_to_reg,
    output logic            reg_dst,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic [1:0]      pc_source,
    output logic            illegal_op,
    output logic [ST_W-1:0] state
);

    state_t     state_q;
    state_t     state_d;
    ctrl_t      ctrl;
    logic [5:0] op6;

    assign op6 = 6'(op);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (op6 == OP_LW || op6 == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (op6 == OP_R) begin
                    state_d = S_EXEC;
                end else if (op6 == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (op6 == OP_J) begin
                    state_d = S_JUMP;
                end else if (op6 == OP_ADDI) begin
                    state_d = S_ADDIEX;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMADR: state_d = (op6 == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    multicycle_ctrl_dec u_dec (
        .state (state_q),
        .ctrl  (ctrl)
    );

    // mem_ready is registered by the memory, so the gated PC strobe is glitch-free
    assign pc_write      = ctrl.pc_write | (ctrl.fetch_gate & mem_ready);
    assign ir_write      = ctrl.fetch_gate & mem_ready;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign illegal_op    = (state_q == S_DECODE) && !op_is_legal(op6);
    assign state         = ST_W'(state_q);

endmodule
